// File: rtl/rr_burst_arbiter_pkg.sv
// Shared types and helpers for the round-robin burst arbiter.
// Optional feature macro: ARB_STATS_EN (see rr_burst_arbiter.sv).
package rr_burst_arbiter_pkg;

    localparam int DEF_N_REQ     = 4;
    localparam int DEF_DATA_W    = 32;
    localparam int DEF_MAX_BEATS = 16;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } arb_state_e;

    // Next requester index after ptr, wrapping n-1 back to 0.
    function automatic int rr_next(input int ptr, input int n);
        return (ptr >= n - 1) ? 0 : ptr + 1;
    endfunction

endpackage

// File: rtl/rr_burst_arbiter_if.sv
// Requester-side and shared-channel signals of the burst arbiter.
// slave: arbiter view, master: requester/sink (bench) view.
interface rr_burst_arbiter_if #(
    parameter int N_REQ  = 4,
    parameter int DATA_W = 32,
    parameter int ID_W   = $clog2(N_REQ)
);
    logic [N_REQ-1:0]        s_valid;
    logic [N_REQ*DATA_W-1:0] s_data;
    logic [N_REQ-1:0]        s_last;
    logic [N_REQ-1:0]        s_ready;
    logic                    m_valid;
    logic [DATA_W-1:0]       m_data;
    logic                    m_last;
    logic [ID_W-1:0]         m_id;
    logic                    m_ready;
    logic                    busy;

    modport slave (
        input  s_valid, s_data, s_last, m_ready,
        output s_ready, m_valid, m_data, m_last, m_id, busy
    );

    modport master (
        output s_valid, s_data, s_last, m_ready,
        input  s_ready, m_valid, m_data, m_last, m_id, busy
    );
endinterface

// File: rtl/rr_burst_arbiter_rr_pick.sv
// Combinational round-robin pick: rotate requests so that ptr is
// position 0, take the lowest set position, map it back to an index.
module rr_burst_arbiter_rr_pick #(
    parameter int N_REQ = 4,
    parameter int PTR_W = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] i_req,
    input  logic [PTR_W-1:0] i_ptr,
    output logic             o_any,
    output logic [PTR_W-1:0] o_idx
);
    logic [PTR_W-1:0] w_pos [N_REQ];
    logic [N_REQ-1:0] w_rot;

    // Position gi of the rotated vector holds request (ptr+gi) mod N_REQ.
    generate
        for (genvar gi = 0; gi < N_REQ; gi++) begin : g_rot
            logic [PTR_W:0] w_sum;
            assign w_sum      = {1'b0, i_ptr} + (PTR_W+1)'(gi);
            assign w_pos[gi]  = (w_sum >= (PTR_W+1)'(N_REQ)) ?
                                PTR_W'(w_sum - (PTR_W+1)'(N_REQ)) : PTR_W'(w_sum);
            assign w_rot[gi]  = i_req[w_pos[gi]];
        end
    endgenerate

    // Priority-encode the rotated vector; lowest position wins.
    always_comb begin
        o_any = |w_rot;
        o_idx = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            if (w_rot[k]) o_idx = w_pos[k];
        end
    end
endmodule

// File: rtl/rr_burst_arbiter.sv
// Round-robin arbiter sharing one valid/ready channel among N_REQ
// requesters; a grant is held for a whole burst or MAX_BEATS beats.
// Optional: define ARB_STATS_EN to add per-requester grant counters.
module rr_burst_arbiter
    import rr_burst_arbiter_pkg::*;
#(
    parameter int N_REQ     = DEF_N_REQ,
    parameter int DATA_W    = DEF_DATA_W,
    parameter int MAX_BEATS = DEF_MAX_BEATS
) (
    input  logic                  clk,
    input  logic                  rst,
    rr_burst_arbiter_if.slave     bus
`ifdef ARB_STATS_EN
    ,
    output logic [N_REQ*16-1:0]   grant_cnt
`endif
);
    localparam int ID_W  = $clog2(N_REQ);
    localparam int CNT_W = $clog2(MAX_BEATS + 1);

    arb_state_e       r_state, w_state_next;
    logic [ID_W-1:0]  r_ptr, w_ptr_next;
    logic [ID_W-1:0]  r_grant, w_grant_next;
    logic [CNT_W-1:0] r_beat_cnt, w_beat_cnt_next;
    logic             w_any;
    logic [ID_W-1:0]  w_pick;
    logic             w_beat;

    rr_burst_arbiter_rr_pick #(
        .N_REQ (N_REQ),
        .PTR_W (ID_W)
    ) u_pick (
        .i_req (bus.s_valid),
        .i_ptr (r_ptr),
        .o_any (w_any),
        .o_idx (w_pick)
    );

    // State, pointer, grant and beat counter registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= IDLE;
            r_ptr      <= '0;
            r_grant    <= '0;
            r_beat_cnt <= '0;
        end else begin
            r_state    <= w_state_next;
            r_ptr      <= w_ptr_next;
            r_grant    <= w_grant_next;
            r_beat_cnt <= w_beat_cnt_next;
        end
    end

    // Next state and channel muxing; in BUSY the granted source passes straight through.
    always_comb begin
        w_state_next    = r_state;
        w_ptr_next      = r_ptr;
        w_grant_next    = r_grant;
        w_beat_cnt_next = r_beat_cnt;
        w_beat          = 1'b0;
        bus.s_ready     = '0;
        bus.m_valid     = 1'b0;
        bus.m_data      = '0;
        bus.m_last      = 1'b0;
        bus.m_id        = '0;
        bus.busy        = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (w_any) begin
                    w_grant_next    = w_pick;
                    w_beat_cnt_next = '0;
                    w_state_next    = BUSY;
                end
            end
            BUSY: begin
                bus.busy             = 1'b1;
                bus.m_valid          = bus.s_valid[r_grant];
                bus.m_data           = bus.s_data[int'(r_grant)*DATA_W +: DATA_W];
                bus.m_last           = bus.s_last[r_grant];
                bus.m_id             = r_grant;
                bus.s_ready[r_grant] = bus.m_ready;
                w_beat               = bus.s_valid[r_grant] && bus.m_ready;
                if (w_beat) begin
                    if (bus.s_last[r_grant] || (r_beat_cnt == CNT_W'(MAX_BEATS - 1))) begin
                        w_ptr_next      = ID_W'(rr_next(int'(r_grant), N_REQ));
                        w_beat_cnt_next = '0;
                        w_state_next    = IDLE;
                    end else begin
                        w_beat_cnt_next = r_beat_cnt + 1'b1;
                    end
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

`ifdef ARB_STATS_EN
    generate
        for (genvar gi = 0; gi < N_REQ; gi++) begin : g_stats
            logic [15:0] r_grant_cnt;
            // Count grants issued to requester gi, saturating at all-ones.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_grant_cnt <= '0;
                end else if ((r_state == IDLE) && w_any && (w_pick == ID_W'(gi))
                             && (r_grant_cnt != 16'hFFFF)) begin
                    r_grant_cnt <= r_grant_cnt + 16'd1;
                end
            end
            assign grant_cnt[gi*16 +: 16] = r_grant_cnt;
        end
    endgenerate
`endif

endmodule

// File: tb/tb_rr_burst_arbiter.sv
// Scoreboard bench for rr_burst_arbiter: per-requester source queues,
// expected beats (id, data, last, cycle) queued when stimulus is loaded.
module tb_rr_burst_arbiter;
    localparam int N  = 4;
    localparam int DW = 32;

    typedef struct {
        int          id;
        logic [31:0] data;
        logic        last;
        int          cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    rr_burst_arbiter_if #(.N_REQ(N), .DATA_W(DW)) bus ();

`ifdef ARB_STATS_EN
    logic [N*16-1:0] grant_cnt;
`endif

    rr_burst_arbiter #(.N_REQ(N), .DATA_W(DW), .MAX_BEATS(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus)
`ifdef ARB_STATS_EN
        ,
        .grant_cnt (grant_cnt)
`endif
    );

    logic [32:0] src_q [N][$];
    exp_t        sb_q [$];
    int          n_chk   = 0;
    int          n_fail  = 0;
    int          cycle   = 0;
    bit          sb_en   = 1'b0;
    bit          bp_mode = 1'b0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cycle);
        end
    endtask

    task automatic add_src(input int i, input logic [31:0] d, input logic l);
        src_q[i].push_back({l, d});
    endtask

    task automatic add_exp(input int id, input logic [31:0] d, input logic l, input int c);
        exp_t e;
        e.id = id; e.data = d; e.last = l; e.cyc = c;
        sb_q.push_back(e);
    endtask

    task automatic drive();
        for (int i = 0; i < N; i++) begin
            if (src_q[i].size() > 0) begin
                bus.s_valid[i]         = 1'b1;
                bus.s_last[i]          = src_q[i][0][32];
                bus.s_data[i*DW +: DW] = src_q[i][0][31:0];
            end else begin
                bus.s_valid[i]         = 1'b0;
                bus.s_last[i]          = 1'b0;
                bus.s_data[i*DW +: DW] = '0;
            end
        end
    endtask

    task automatic tick();
        logic [N-1:0] pop;
        exp_t e;
        @(negedge clk);
        pop = bus.s_valid & bus.s_ready;
        if (sb_en) begin
            if (cycle == 0) chk("bubble_m_valid", 64'(bus.m_valid), 64'd0);
            if (bp_mode && cycle >= 1 && cycle <= 8)
                chk("bp_s_ready", 64'(bus.s_ready), {60'd0, 3'b000, bus.m_ready});
            if (bus.m_valid && bus.m_ready) begin
                $display("beat cyc=%0d id=%0d data=%h last=%0b", cycle, bus.m_id, bus.m_data, bus.m_last);
                if (sb_q.size() == 0) begin
                    chk("unexpected_beat", 64'd1, 64'd0);
                end else begin
                    e = sb_q.pop_front();
                    chk("m_id",   64'(bus.m_id),   64'(e.id));
                    chk("m_data", 64'(bus.m_data), 64'(e.data));
                    chk("m_last", 64'(bus.m_last), 64'(e.last));
                    if (e.cyc >= 0) chk("beat_cycle", 64'(cycle), 64'(e.cyc));
                end
            end
        end
        @(posedge clk);
        #1;
        cycle++;
        for (int i = 0; i < N; i++) if (pop[i]) void'(src_q[i].pop_front());
        if (bp_mode) bus.m_ready = (cycle % 2 == 0);
        drive();
    endtask

    task automatic start();
        cycle = 0;
        drive();
    endtask

    task automatic run(input int limit);
        int n = 0;
        while (sb_q.size() > 0 && n < limit) begin
            tick();
            n++;
        end
        if (sb_q.size() > 0) begin
            chk("timeout_pending", 64'(sb_q.size()), 64'd0);
            sb_q.delete();
        end
    endtask

    task automatic chk_all_zero(input string pfx);
        chk({pfx, "_m_valid"}, 64'(bus.m_valid), 64'd0);
        chk({pfx, "_s_ready"}, 64'(bus.s_ready), 64'd0);
        chk({pfx, "_busy"},    64'(bus.busy),    64'd0);
        chk({pfx, "_m_id"},    64'(bus.m_id),    64'd0);
        chk({pfx, "_m_last"},  64'(bus.m_last),  64'd0);
        chk({pfx, "_m_data"},  64'(bus.m_data),  64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.m_ready = 1'b1;
        drive();
        repeat (2) @(posedge clk);
        #1;
        chk_all_zero("reset");
        rst = 1'b0;

        // Reset mid-burst with every requester valid.
        for (int k = 0; k < 2; k++) add_src(0, 32'h0F00 + k, 1'b1);
        for (int k = 0; k < 6; k++) add_src(1, 32'h0F10 + k, k == 5);
        for (int k = 0; k < 2; k++) add_src(2, 32'h0F20 + k, k == 1);
        for (int k = 0; k < 2; k++) add_src(3, 32'h0F30 + k, k == 1);
        start();
        repeat (4) tick();
        chk("pre_rst_busy",    64'(bus.busy),    64'd1);
        chk("pre_rst_s_valid", 64'(bus.s_valid), 64'hF);
        #2 rst = 1'b1;
        #1;
        chk_all_zero("midrst");
        for (int i = 0; i < N; i++) src_q[i].delete();
        drive();
        @(posedge clk);
        #1 rst = 1'b0;
        sb_en = 1'b1;

        // Rotation from ptr=0: 1-beat bursts, one idle cycle between grants.
        for (int i = 0; i < N; i++) add_src(i, 32'h0100 * i, 1'b1);
        add_src(0, 32'h0001, 1'b1);
        add_src(1, 32'h0101, 1'b1);
        add_exp(0, 32'h0000, 1'b1, 1);
        add_exp(1, 32'h0100, 1'b1, 3);
        add_exp(2, 32'h0200, 1'b1, 5);
        add_exp(3, 32'h0300, 1'b1, 7);
        add_exp(0, 32'h0001, 1'b1, 9);
        add_exp(1, 32'h0101, 1'b1, 11);
        start();
        run(60);

        // Single requester 2, 3-beat burst.
        for (int k = 0; k < 3; k++) begin
            add_src(2, 32'hA000 + k, k == 2);
            add_exp(2, 32'hA000 + k, k == 2, 1 + k);
        end
        start();
        run(60);
        chk("single_busy_after", 64'(bus.busy), 64'd0);

        // Wrap: ptr=3, requesters 3 and 0 valid.
        add_src(3, 32'h4300, 1'b1);
        add_src(0, 32'h4000, 1'b1);
        add_exp(3, 32'h4300, 1'b1, 1);
        add_exp(0, 32'h4000, 1'b1, 3);
        start();
        run(60);

        // Fairness cap: 20-beat burst on 1 is cut after 16, 2 gets a turn.
        for (int k = 0; k < 20; k++) add_src(1, 32'h5100 + k, k == 19);
        add_src(2, 32'h5200, 1'b1);
        for (int k = 0; k < 16; k++) add_exp(1, 32'h5100 + k, 1'b0, 1 + k);
        add_exp(2, 32'h5200, 1'b1, 18);
        for (int k = 16; k < 20; k++) add_exp(1, 32'h5100 + k, k == 19, 20 + k - 16);
        start();
        run(80);

        // Backpressure: m_ready alternates, beats only when it is high.
        bp_mode = 1'b1;
        for (int k = 0; k < 4; k++) begin
            add_src(0, 32'h6000 + k, k == 3);
            add_exp(0, 32'h6000 + k, k == 3, 2 + 2 * k);
        end
        start();
        run(60);
        bp_mode = 1'b0;
        bus.m_ready = 1'b1;
        tick();
        chk("bp_busy_after", 64'(bus.busy), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
